// File: rtl/bus_timer.sv
// Memory-mapped 16-bit interval timer on the 65C02 bus: 8-byte register window,
// RDY-driven wait states, registered read data and a level IRQ on underflow.
module bus_timer #(
    parameter logic [15:0] BASE        = 16'hFE00,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic [15:0] AD,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic        RDY,
    output logic [7:0]  RD_DATA,
    output logic        RD_VALID,
    output logic        IRQ
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    localparam logic [2:0] OFF_CNT_LO = 3'd0;
    localparam logic [2:0] OFF_CNT_HI = 3'd1;
    localparam logic [2:0] OFF_RLD_LO = 3'd2;
    localparam logic [2:0] OFF_RLD_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;
    localparam logic [2:0] OFF_PSC    = 3'd6;

    logic [3:0]  wcnt_q,    wcnt_d;
    logic [15:0] cnt_q,     cnt_d;
    logic [7:0]  snap_q,    snap_d;
    logic [7:0]  rld_lo_q,  rld_lo_d;
    logic [7:0]  rld_hi_q,  rld_hi_d;
    logic [7:0]  psc_q,     psc_d;
    logic [7:0]  pcnt_q,    pcnt_d;
    logic        en_q,      en_d;
    logic        auto_q,    auto_d;
    logic        ie_q,      ie_d;
    logic        if_q,      if_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        irq_q,     irq_d;

    logic       hit;
    logic       commit;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] off;
    logic       wr_rld_hi;
    logic       wr_ctrl;
    logic       wr_status;
    logic       ctrl_kill;
    logic       tick;
    logic       tick_eff;
    logic       underflow;
    logic [7:0] rd_mux;

    function automatic logic [7:0] read_reg(
        input logic [2:0]  sel,
        input logic [15:0] cnt,
        input logic [7:0]  snap,
        input logic [7:0]  rld_lo,
        input logic [7:0]  rld_hi,
        input logic        en,
        input logic        auto_rl,
        input logic        ie,
        input logic        irq_flag,
        input logic [7:0]  psc
    );
        logic [7:0] v;
        v = 8'h00;
        case (sel)
            OFF_CNT_LO: v = cnt[7:0];
            OFF_CNT_HI: v = snap;
            OFF_RLD_LO: v = rld_lo;
            OFF_RLD_HI: v = rld_hi;
            OFF_CTRL:   v = {5'b0, ie, auto_rl, en};
            OFF_STATUS: v = {en, 6'b0, irq_flag};
            OFF_PSC:    v = psc;
            default:    v = 8'h00;
        endcase
        return v;
    endfunction

    always_comb begin
        hit       = (AD[15:3] == BASE[15:3]);
        RDY       = ~hit | (wcnt_q == WS);
        commit    = hit & RDY;
        wr_en     = commit & WE;
        rd_en     = commit & ~WE;
        off       = AD[2:0];
        wr_rld_hi = wr_en & (off == OFF_RLD_HI);
        wr_ctrl   = wr_en & (off == OFF_CTRL);
        wr_status = wr_en & (off == OFF_STATUS);
        // A reload load or an EN-clearing CTRL write on a tick edge takes precedence over the tick.
        ctrl_kill = wr_ctrl & ~DO[0];
        tick      = en_q & (pcnt_q == psc_q);
        tick_eff  = tick & ~wr_rld_hi & ~ctrl_kill;
        underflow = tick_eff & (cnt_q == 16'd0);
        rd_mux    = read_reg(off, cnt_q, snap_q, rld_lo_q, rld_hi_q,
                             en_q, auto_q, ie_q, if_q, psc_q);
    end

    always_comb begin
        wcnt_d     = RDY ? 4'd0 : wcnt_q + 4'd1;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        rld_lo_d   = rld_lo_q;
        rld_hi_d   = rld_hi_q;
        psc_d      = psc_q;
        pcnt_d     = pcnt_q;
        en_d       = en_q;
        auto_d     = auto_q;
        ie_d       = ie_q;
        if_d       = if_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;
        irq_d      = if_q & ie_q;

        if (en_q) begin
            pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        end

        if (tick_eff) begin
            if (cnt_q != 16'd0) begin
                cnt_d = cnt_q - 16'd1;
            end else if (auto_q) begin
                cnt_d = {rld_hi_q, rld_lo_q};
            end else begin
                en_d = 1'b0;
            end
        end

        // Set from underflow is evaluated last so it beats a same-edge STATUS clear.
        if (wr_status && DO[0]) begin
            if_d = 1'b0;
        end
        if (underflow) begin
            if_d = 1'b1;
        end

        if (wr_en) begin
            case (off)
                OFF_RLD_LO: rld_lo_d = DO;
                OFF_RLD_HI: begin
                    rld_hi_d = DO;
                    cnt_d    = {DO, rld_lo_q};
                    pcnt_d   = 8'd0;
                end
                OFF_CTRL: begin
                    en_d   = DO[0];
                    auto_d = DO[1];
                    ie_d   = DO[2];
                    if (DO[0] && !en_q) begin
                        pcnt_d = 8'd0;
                    end
                end
                OFF_PSC: psc_d = DO;
                default: ;
            endcase
        end

        if (rd_en) begin
            rd_data_d = rd_mux;
            if (off == OFF_CNT_LO) begin
                snap_d = cnt_q[15:8];
            end
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            wcnt_q     <= 4'd0;
            cnt_q      <= 16'd0;
            snap_q     <= 8'd0;
            rld_lo_q   <= 8'd0;
            rld_hi_q   <= 8'd0;
            psc_q      <= 8'd0;
            pcnt_q     <= 8'd0;
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            if_q       <= 1'b0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wcnt_q     <= wcnt_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            rld_lo_q   <= rld_lo_d;
            rld_hi_q   <= rld_hi_d;
            psc_q      <= psc_d;
            pcnt_q     <= pcnt_d;
            en_q       <= en_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            if_q       <= if_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign IRQ      = irq_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer with WAIT_STATES=2: bus timing, register map,
// underflow/IRQ behaviour, snapshot reads, same-edge priorities and async reset.
module tb_bus_timer;

    localparam int WS = 2;

    logic        clk;
    logic        RST_N;
    logic [15:0] AD;
    logic [7:0]  DO;
    logic        WE;
    logic        RDY;
    logic [7:0]  RD_DATA;
    logic        RD_VALID;
    logic        IRQ;

    int total;
    int bad;

    bus_timer #(
        .BASE        (16'hFE00),
        .WAIT_STATES (WS)
    ) dut (
        .clk      (clk),
        .RST_N    (RST_N),
        .AD       (AD),
        .DO       (DO),
        .WE       (WE),
        .RDY      (RDY),
        .RD_DATA  (RD_DATA),
        .RD_VALID (RD_VALID),
        .IRQ      (IRQ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge, returns at the negedge following the commit edge.
    task automatic bus_op(input string tag, input logic [15:0] a, input logic w,
                          input logic [7:0] d, input logic exp_hit);
        int stalls;
        AD = a; WE = w; DO = d; stalls = 0;
        #1;
        while (RDY !== 1'b1 && stalls < 20) begin
            @(negedge clk); #1;
            stalls++;
        end
        check({tag, "_stalls"}, 16'(stalls), exp_hit ? 16'(WS) : 16'd0);
        @(posedge clk); #1;
        AD = 16'h0000; WE = 1'b0; DO = 8'h00;
        @(negedge clk);
        check({tag, "_rdvalid"}, {15'b0, RD_VALID}, {15'b0, exp_hit & ~w});
    endtask

    task automatic wr(input string tag, input logic [2:0] off, input logic [7:0] d);
        bus_op(tag, {13'h1FC0, off}, 1'b1, d, 1'b1);
    endtask

    task automatic rd(input string tag, input logic [2:0] off, input logic [7:0] exp);
        bus_op(tag, {13'h1FC0, off}, 1'b0, 8'h00, 1'b1);
        check({tag, "_data"}, {8'h00, RD_DATA}, {8'h00, exp});
    endtask

    task automatic wait_irq(input string tag, input int exp_cycles);
        int cycles;
        cycles = 0;
        while (IRQ !== 1'b1 && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, 16'(cycles), 16'(exp_cycles));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST_N = 1'b0;
        AD    = 16'h0000;
        DO    = 8'h00;
        WE    = 1'b0;
        #12;
        check("rst_rdy",     {15'b0, RDY},      16'd1);
        check("rst_rdvalid", {15'b0, RD_VALID}, 16'd0);
        check("rst_irq",     {15'b0, IRQ},      16'd0);
        check("rst_rddata",  {8'h00, RD_DATA},  16'h0000);
        RST_N = 1'b1;
        @(negedge clk);

        // Basic bus timing and register map
        rd("rd_ctrl_rst", 3'd4, 8'h00);
        rd("rd_psc_rst", 3'd6, 8'h00);
        @(negedge clk);
        check("rdvalid_pulse", {15'b0, RD_VALID}, 16'd0);
        wr("wr_psc", 3'd6, 8'h5A);
        rd("rd_psc", 3'd6, 8'h5A);
        wr("wr_off7", 3'd7, 8'hAA);
        rd("rd_off7", 3'd7, 8'h00);
        bus_op("miss_fe08", 16'hFE08, 1'b0, 8'h00, 1'b0);

        // Auto-reload underflow, IRQ, stop on tick edge, IF clear
        wr("t1_rlo", 3'd2, 8'h03);
        wr("t1_rhi", 3'd3, 8'h00);
        wr("t1_psc", 3'd6, 8'h00);
        wr("t1_ctrl", 3'd4, 8'h07);
        wait_irq("t1_irq_lat", 5);
        rd("t1_status", 3'd5, 8'h81);
        wr("t1_stop", 3'd4, 8'h06);
        rd("t1_cnt_frozen", 3'd0, 8'h01);
        wr("t1_clr", 3'd5, 8'h01);
        check("t1_irq_hold", {15'b0, IRQ}, 16'd1);
        @(negedge clk);
        check("t1_irq_drop", {15'b0, IRQ}, 16'd0);
        rd("t1_status2", 3'd5, 8'h00);
        rd("t1_ctrl_rb", 3'd4, 8'h06);

        // One-shot with prescaler
        wr("t2_rlo", 3'd2, 8'h01);
        wr("t2_rhi", 3'd3, 8'h00);
        wr("t2_psc", 3'd6, 8'h01);
        wr("t2_ctrl", 3'd4, 8'h05);
        wait_irq("t2_irq_lat", 5);
        rd("t2_status", 3'd5, 8'h01);
        rd("t2_cnt", 3'd0, 8'h00);
        rd("t2_ctrl_rb", 3'd4, 8'h04);
        wr("t2_clr", 3'd5, 8'h01);
        wr("t2_ctrl0", 3'd4, 8'h00);

        // High-byte snapshot
        wr("t3_rlo", 3'd2, 8'hFF);
        wr("t3_rhi", 3'd3, 8'h01);
        wr("t3_psc", 3'd6, 8'h00);
        wr("t3_ctrl", 3'd4, 8'h01);
        rd("t3_lo1", 3'd0, 8'hFD);
        repeat (300) @(negedge clk);
        rd("t3_hi1", 3'd1, 8'h01);
        rd("t3_lo2", 3'd0, 8'hCB);
        rd("t3_hi2", 3'd1, 8'h00);
        wr("t3_stop", 3'd4, 8'h00);

        // Underflow coincident with STATUS clear
        wr("t4_rlo", 3'd2, 8'h00);
        wr("t4_rhi", 3'd3, 8'h00);
        wr("t4_psc", 3'd6, 8'h02);
        wr("t4_ctrl", 3'd4, 8'h01);
        wr("t4_clr", 3'd5, 8'h01);
        rd("t4_status", 3'd5, 8'h01);

        // Async reset during a stalled access
        wr("t5_ie", 3'd4, 8'h04);
        @(negedge clk);
        check("t5_irq_pre", {15'b0, IRQ}, 16'd1);
        AD = 16'hFE06; WE = 1'b0;
        #1;
        check("t5_stall0", {15'b0, RDY}, 16'd0);
        @(negedge clk); #1;
        check("t5_stall1", {15'b0, RDY}, 16'd0);
        RST_N = 1'b0;
        #1;
        check("t5_rst_rdy",     {15'b0, RDY},      16'd0);
        check("t5_rst_irq",     {15'b0, IRQ},      16'd0);
        check("t5_rst_rdvalid", {15'b0, RD_VALID}, 16'd0);
        check("t5_rst_rddata",  {8'h00, RD_DATA},  16'h0000);
        AD = 16'h0000;
        #1;
        check("t5_rst_nohit", {15'b0, RDY}, 16'd1);
        RST_N = 1'b1;
        @(negedge clk);
        rd("t5_ctrl", 3'd4, 8'h00);
        rd("t5_status", 3'd5, 8'h00);
        rd("t5_rlo", 3'd2, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
